// File: rtl/csa_accumulator.sv
// Carry-save batch accumulator: sums redundant (xs+xc) pairs, then resolves CHUNK bits/cycle; result NCH+1 cycles after last beat.
// Backpressure: in_ready only in ACC; result held in OUT until out_ready, operands ignored meanwhile.
module csa_accumulator #(
  parameter int WL     = 8,
  parameter int GUARD  = 2,
  parameter int CHUNK  = 4,
  parameter int SIGNED = 0,
  parameter int CW     = 8,
  localparam int AW    = WL + GUARD
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_start,
  input  logic          in_last,
  input  logic [WL-1:0] xs,
  input  logic [WL-1:0] xc,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_sum,
  output logic          out_ovf,
  output logic [CW-1:0] out_cnt
);

  localparam int NCH = (AW + CHUNK - 1) / CHUNK;
  localparam int PW  = NCH * CHUNK;
  localparam int IW  = $clog2(NCH + 1);
  localparam logic [CW-1:0] OVF_LIM = CW'(1 << (GUARD - 1));

  localparam logic [1:0] ST_ACC = 2'd0;
  localparam logic [1:0] ST_RES = 2'd1;
  localparam logic [1:0] ST_OUT = 2'd2;

  logic [1:0]    state;
  logic [AW-1:0] ws_q, wc_q, res_q;
  logic [CW-1:0] cnt_q;
  logic [IW-1:0] idx_q;
  logic          carry_q;

  logic          xfer;
  logic [AW-1:0] ext_s, ext_c;
  logic [AW-1:0] s1, c1, s2, c2;
  logic [PW-1:0] ws_pad, wc_pad;
  logic [IW-1:0] sel;
  logic [CHUNK:0] csum;
  logic [AW-1:0] ins;

  assign in_ready = (state == ST_ACC);
  assign xfer     = in_valid & in_ready;

  assign ext_s = (SIGNED != 0) ? {{GUARD{xs[WL-1]}}, xs} : {{GUARD{1'b0}}, xs};
  assign ext_c = (SIGNED != 0) ? {{GUARD{xc[WL-1]}}, xc} : {{GUARD{1'b0}}, xc};

  // 4:2 compression as two chained full-adder rows; carries leaving bit AW-1 fall off the shift
  always_comb begin
    s1 = ws_q ^ wc_q ^ ext_s;
    c1 = ((ws_q & wc_q) | (ws_q & ext_s) | (wc_q & ext_s)) << 1;
    s2 = s1 ^ c1 ^ ext_c;
    c2 = ((s1 & c1) | (s1 & ext_c) | (c1 & ext_c)) << 1;
  end

  assign ws_pad = PW'(ws_q);
  assign wc_pad = PW'(wc_q);
  assign sel    = (idx_q < IW'(NCH)) ? idx_q : '0;

  always_comb begin
    csum = (CHUNK+1)'(ws_pad[sel*CHUNK +: CHUNK])
         + (CHUNK+1)'(wc_pad[sel*CHUNK +: CHUNK])
         + (CHUNK+1)'(carry_q);
    ins  = AW'(csum[CHUNK-1:0]) << (sel * CHUNK);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_ACC;
      ws_q    <= '0;
      wc_q    <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      case (state)
        ST_ACC: begin
          if (xfer) begin
            if (in_start) begin
              ws_q  <= ext_s;
              wc_q  <= ext_c;
              cnt_q <= CW'(1);
            end else begin
              ws_q  <= s2;
              wc_q  <= c2;
              cnt_q <= (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
            end
            if (in_last) begin
              state   <= ST_RES;
              idx_q   <= '0;
              carry_q <= 1'b0;
              res_q   <= '0;
            end
          end
        end
        ST_RES: begin
          // One extra cycle after the last chunk lands before the result is presented
          if (idx_q == IW'(NCH)) begin
            state <= ST_OUT;
          end else begin
            res_q   <= res_q | ins;
            carry_q <= csum[CHUNK];
            idx_q   <= idx_q + 1'b1;
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            state <= ST_ACC;
            ws_q  <= '0;
            wc_q  <= '0;
            cnt_q <= '0;
            res_q <= '0;
          end
        end
        default: state <= ST_ACC;
      endcase
    end
  end

  assign out_valid = (state == ST_OUT);
  assign out_sum   = out_valid ? res_q : '0;
  assign out_cnt   = out_valid ? cnt_q : '0;
  assign out_ovf   = out_valid & (cnt_q > OVF_LIM);

endmodule

// File: tb/tb_csa_accumulator.sv
// Bench for csa_accumulator: unsigned and signed instances share stimulus and are checked
// against an integer-arithmetic batch model.
module tb_csa_accumulator;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_start, in_last, out_ready;
  logic [7:0] xs, xc;

  logic       in_ready_u, out_valid_u, out_ovf_u;
  logic [9:0] out_sum_u;
  logic [7:0] out_cnt_u;
  logic       in_ready_s, out_valid_s, out_ovf_s;
  logic [9:0] out_sum_s;
  logic [7:0] out_cnt_s;

  int total = 0;
  int bad   = 0;

  logic [7:0] bxs[$];
  logic [7:0] bxc[$];
  logic [9:0] last_eu;

  always #5 clk = ~clk;

  csa_accumulator #(.WL(8), .GUARD(2), .CHUNK(4), .SIGNED(0), .CW(8)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_u),
    .in_start(in_start), .in_last(in_last), .xs(xs), .xc(xc),
    .out_valid(out_valid_u), .out_ready(out_ready), .out_sum(out_sum_u),
    .out_ovf(out_ovf_u), .out_cnt(out_cnt_u)
  );

  csa_accumulator #(.WL(8), .GUARD(2), .CHUNK(4), .SIGNED(1), .CW(8)) u_dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_start(in_start), .in_last(in_last), .xs(xs), .xc(xc),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_sum(out_sum_s),
    .out_ovf(out_ovf_s), .out_cnt(out_cnt_s)
  );

  function automatic int extv(logic [7:0] v, bit sgn);
    return sgn ? int'($signed(v)) : int'(v);
  endfunction

  // Feeds bxs/bxc as one batch, measures latency and checks the presented result.
  // Leaves both DUTs holding their result (out_ready=0).
  task automatic do_batch(input bit first_start);
    int au, as_, lat, n;
    logic [9:0] eu, es;
    logic [7:0] ec;
    logic       eo;
    n = bxs.size();
    au = 0;
    as_ = 0;
    for (int i = 0; i < n; i++) begin
      au  += extv(bxs[i], 0) + extv(bxc[i], 0);
      as_ += extv(bxs[i], 1) + extv(bxc[i], 1);
    end
    eu = 10'(au);
    es = 10'(as_);
    ec = (n > 255) ? 8'd255 : 8'(n);
    eo = (n > 2);
    last_eu = eu;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      xs = bxs[i];
      xc = bxc[i];
      in_start = (i == 0) && first_start;
      in_last = (i == n - 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_start = 1'b0; in_last = 1'b0;
    xs = 8'($urandom); xc = 8'($urandom);
    lat = 0;
    while (!out_valid_u && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    total++; if (lat !== 4) begin bad++; $display("FAIL latency: got %0d want 4", lat); end
    total++; if (out_valid_s !== 1'b1) begin bad++; $display("FAIL valid_s: got %b want 1", out_valid_s); end
    total++; if (out_sum_u !== eu) begin bad++; $display("FAIL sum_u: got %0d want %0d", out_sum_u, eu); end
    total++; if (out_sum_s !== es) begin bad++; $display("FAIL sum_s: got %h want %h", out_sum_s, es); end
    total++; if (out_cnt_u !== ec) begin bad++; $display("FAIL cnt_u: got %0d want %0d", out_cnt_u, ec); end
    total++; if (out_ovf_u !== eo) begin bad++; $display("FAIL ovf_u: got %b want %b", out_ovf_u, eo); end
    total++; if (out_ovf_s !== eo) begin bad++; $display("FAIL ovf_s: got %b want %b", out_ovf_s, eo); end
    total++; if (in_ready_u !== 1'b0) begin bad++; $display("FAIL ready_in_out: got %b want 0", in_ready_u); end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++; if (in_ready_u !== 1'b1) begin bad++; $display("FAIL release_ready: got %b want 1", in_ready_u); end
    total++; if (out_valid_u !== 1'b0) begin bad++; $display("FAIL release_valid: got %b want 0", out_valid_u); end
    total++; if (out_sum_u !== 10'd0 || out_cnt_u !== 8'd0) begin
      bad++; $display("FAIL release_zero: got sum=%0d cnt=%0d want 0/0", out_sum_u, out_cnt_u);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_start = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    xs = '0; xc = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    total++; if (in_ready_u !== 1'b1 || in_ready_s !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b/%b want 1/1", in_ready_u, in_ready_s); end
    total++; if (out_valid_u !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid_u); end
    total++; if (out_sum_u !== 10'd0 || out_cnt_u !== 8'd0 || out_ovf_u !== 1'b0) begin
      bad++; $display("FAIL reset_outs: got sum=%0d cnt=%0d ovf=%b want 0", out_sum_u, out_cnt_u, out_ovf_u);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    bxs = '{8'd10, 8'd255}; bxc = '{8'd5, 8'd255};
    do_batch(1'b1);
    total++; if (out_sum_u !== 10'd525 || out_cnt_u !== 8'd2 || out_ovf_u !== 1'b0) begin
      bad++; $display("FAIL two_beat: got sum=%0d cnt=%0d ovf=%b want 525/2/0", out_sum_u, out_cnt_u, out_ovf_u);
    end
    release_out();
    bxs = '{8'd3}; bxc = '{8'd4};
    do_batch(1'b1);
    total++; if (out_sum_u !== 10'd7 || out_cnt_u !== 8'd1 || out_ovf_u !== 1'b0) begin
      bad++; $display("FAIL single_beat: got sum=%0d cnt=%0d ovf=%b want 7/1/0", out_sum_u, out_cnt_u, out_ovf_u);
    end
    release_out();
    bxs = '{8'd255, 8'd255, 8'd255, 8'd255}; bxc = '{8'd255, 8'd255, 8'd255, 8'd255};
    do_batch(1'b1);
    total++; if (out_sum_u !== 10'd1016 || out_cnt_u !== 8'd4 || out_ovf_u !== 1'b1) begin
      bad++; $display("FAIL overflow: got sum=%0d cnt=%0d ovf=%b want 1016/4/1", out_sum_u, out_cnt_u, out_ovf_u);
    end
    release_out();
    bxs = '{8'hFF, 8'hFE}; bxc = '{8'h00, 8'h00};
    do_batch(1'b1);
    total++; if (out_sum_s !== 10'h3FD || out_ovf_s !== 1'b0) begin
      bad++; $display("FAIL signed: got sum=%h ovf=%b want 3fd/0", out_sum_s, out_ovf_s);
    end
    release_out();
  endtask

  task automatic test_hold_out();
    bxs = '{8'd20, 8'd30, 8'd40}; bxc = '{8'd1, 8'd2, 8'd3};
    do_batch(1'b1);
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; in_start = 1'b1; in_last = 1'b1;
      xs = 8'($urandom); xc = 8'($urandom);
      @(posedge clk); #1;
      total++; if (out_valid_u !== 1'b1 || out_sum_u !== last_eu || in_ready_u !== 1'b0) begin
        bad++; $display("FAIL hold_c%0d: got valid=%b sum=%0d ready=%b want 1/%0d/0", c, out_valid_u, out_sum_u, in_ready_u, last_eu);
      end
    end
    in_valid = 1'b0; in_start = 1'b0; in_last = 1'b0;
    release_out();
    bxs = '{8'd7, 8'd9}; bxc = '{8'd11, 8'd13};
    do_batch(1'b0);
    release_out();
  endtask

  task automatic test_reset_in_res();
    bxs = '{8'd100, 8'd200}; bxc = '{8'd50, 8'd60};
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; xs = bxs[i]; xc = bxc[i];
      in_start = (i == 0); in_last = (i == 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_start = 1'b0; in_last = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    total++; if (in_ready_u !== 1'b1 || out_valid_u !== 1'b0 || out_sum_u !== 10'd0) begin
      bad++; $display("FAIL reset_mid_res: got ready=%b valid=%b sum=%0d want 1/0/0", in_ready_u, out_valid_u, out_sum_u);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    total++; if (in_ready_u !== 1'b1 || out_valid_u !== 1'b0) begin
      bad++; $display("FAIL after_reset: got ready=%b valid=%b want 1/0", in_ready_u, out_valid_u);
    end
    // no in_start: anything left in the accumulator would show up in the sum
    bxs = '{8'd33, 8'd44}; bxc = '{8'd55, 8'd66};
    do_batch(1'b0);
    release_out();
  endtask

  task automatic test_random();
    int n;
    for (int b = 0; b < 25; b++) begin
      n = $urandom_range(1, 6);
      bxs = {}; bxc = {};
      for (int i = 0; i < n; i++) begin
        bxs.push_back(8'($urandom));
        bxc.push_back(8'($urandom));
      end
      do_batch(1'b1);
      release_out();
    end
  endtask

  task automatic test_saturate();
    bxs = {}; bxc = {};
    for (int i = 0; i < 260; i++) begin
      bxs.push_back(8'($urandom));
      bxc.push_back(8'($urandom));
    end
    do_batch(1'b1);
    release_out();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold_out();
    test_reset_in_res();
    test_random();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/csa_accumulator.md
CSA_ACCUMULATOR -- requirements
Module: csa_accumulator

Interface
REQ-001 Parameter WL, 8: operand width in bits (>=2).
REQ-002 Parameter GUARD, 2: accumulator guard bits (>=1); AW = WL+GUARD.
REQ-003 Parameter CHUNK, 4: bits resolved per cycle in carry-propagate phase (1..AW); NCH = ceil(AW/CHUNK).
REQ-004 Parameter SIGNED, 0: 1 = operands sign-extended to AW, 0 = zero-extended.
REQ-005 Parameter CW, 8: operand counter width.
REQ-006 clk  in  1  single clock, rising edge.
REQ-007 Reset  in  1  asynchronous, active-high reset.
REQ-008 in_valid  in  1  operand pair valid.
REQ-009 in_ready  out  1  block accepts operand pair.
REQ-010 in_start  in  1  qualifies beat as first of batch; clears accumulator before adding.
REQ-011 in_last  in  1  qualifies beat as last of batch.
REQ-012 xs, xc  in  WL each  redundant operand pair; value = xs + xc.
REQ-013 out_valid  out  1  result valid.
REQ-014 out_ready  in  1  result consumer ready.
REQ-015 out_sum  out  AW  resolved batch sum modulo 2^AW.
REQ-016 out_ovf  out  1  guard-range overflow flag.
REQ-017 out_cnt  out  CW  operands accepted in batch (saturating).

Function
REQ-018 State machine SHALL have states ACC, RES, OUT; reset state ACC.
REQ-019 in_ready SHALL equal (state==ACC); transfer = in_valid & in_ready.
REQ-020 Redundant accumulator (Ws, Wc), AW bits each; value = Ws+Wc mod 2^AW.
REQ-021 On transfer with in_start: Ws <= ext(xs), Wc <= ext(xc), cnt <= 1.
REQ-022 On transfer without in_start: (Ws,Wc) <= 4:2 compression of Ws, Wc, ext(xs), ext(xc), carries shifted left one bit, carry/hout out of bit AW-1 discarded; cnt <= cnt+1 saturating at 2^CW-1.
REQ-023 Transfer with in_last: ACC->RES, chunk index 0, propagate carry 0; in_start and in_last together = single-operand batch.
REQ-024 RES: each cycle adds CHUNK bits of Ws and Wc plus carry into result register, LSB chunk first; top chunk truncated to AW; after NCH cycles -> OUT.
REQ-025 Latency: last operand accepted at edge T -> out_valid high after edge T+NCH+1.
REQ-026 OUT: out_valid=1; out_sum, out_ovf, out_cnt held stable until out_ready=1; then -> ACC with Ws, Wc, cnt cleared to 0.
REQ-027 out_ovf = 1 iff batch cnt > 2^(GUARD-1); out_sum still reported mod 2^AW.
REQ-028 in_valid, in_start, in_last, xs, xc SHALL be ignored in RES and OUT.
REQ-029 out_sum, out_ovf, out_cnt SHALL read 0 whenever out_valid=0.

Reset
REQ-030 Reset high SHALL immediately force state ACC, Ws=Wc=0, cnt=0, result=0, in_ready=1, out_valid=0, out_sum=0, out_ovf=0, out_cnt=0, regardless of state (including mid-RES or OUT); no partial result survives.

Verification (WL=8, GUARD=2, CHUNK=4, AW=10, NCH=3 unless noted)
REQ-031 Reset pulse during RES -> next cycle in_ready=1, out_valid=0, out_sum=0; new batch then completes normally.
REQ-032 SIGNED=0: (10,5) start, (255,255) last -> out_sum=525, out_cnt=2, out_ovf=0, out_valid 4 cycles after last transfer.
REQ-033 Single beat start+last (3,4) -> out_sum=7, out_cnt=1, out_ovf=0.
REQ-034 SIGNED=0: four beats (255,255) -> out_sum=1016 (2040 mod 1024), out_cnt=4, out_ovf=1.
REQ-035 SIGNED=1: (0xFF,0x00) start, (0xFE,0x00) last -> out_sum=10'h3FD (-3), out_ovf=0.
REQ-036 Hold out_ready=0 for 5 cycles in OUT while driving in_valid=1 -> out_valid, out_sum stable, in_ready=0, no operand absorbed; after out_ready=1, next batch starting without in_start accumulates from 0.
